// File: rtl/univ_shift_reg.sv
// Universal shift register with manual modes and a counted burst-shift FSM.
// Optional macro UNIV_SHIFT_REG_ROTATE_EN adds rot_i to recirculate the outgoing bit.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clr_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sr_ser_i,
    input  logic             sl_ser_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             dir_i,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             sr_in, sl_in;
    logic [WIDTH-1:0] shr, shl;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign sr_in = rot_i ? q_q[0]       : sr_ser_i;
    assign sl_in = rot_i ? q_q[WIDTH-1] : sl_ser_i;
`else
    assign sr_in = sr_ser_i;
    assign sl_in = sl_ser_i;
`endif

    assign shr = {sr_in, q_q[WIDTH-1:1]};
    assign shl = {q_q[WIDTH-2:0], sl_in};

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        q_d     = q_q;
        if (clr_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            q_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        cnt_d   = len_i;
                        dir_d   = dir_i;
                        state_d = (len_i == '0) ? StDone : StShift;
                    end else begin
                        unique case (mode_i)
                            2'b01:   q_d = shr;
                            2'b10:   q_d = shl;
                            2'b11:   q_d = d_i;
                            default: q_d = q_q;
                        endcase
                    end
                end
                StShift: begin
                    q_d   = dir_q ? shl : shr;
                    cnt_d = cnt_q - 1'b1;
                    // The edge doing the final shift also hands over to DONE.
                    if (cnt_q == CNT_W'(1)) state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        q_o    = q_q;
        busy_o = (state_q == StShift);
        done_o = (state_q == StDone);
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8).
// Define UNIV_SHIFT_REG_ROTATE_EN for both files to include the rotate vector.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sr_ser;
    logic       sl_ser;
    logic       start;
    logic [3:0] len;
    logic       dir;
    logic       rot;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int dones;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .clr_i    (clr),
        .mode_i   (mode),
        .d_i      (d),
        .sr_ser_i (sr_ser),
        .sl_ser_i (sl_ser),
        .start_i  (start),
        .len_i    (len),
        .dir_i    (dir),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot_i    (rot),
`endif
        .q_o      (q),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        mode = 2'b11;
        d    = val;
        tick();
        mode = 2'b00;
    endtask

    initial begin
        resetn = 1'b0; clr = 1'b0; mode = 2'b00; d = '0; sr_ser = 1'b0; sl_ser = 1'b0;
        start = 1'b0; len = '0; dir = 1'b0; rot = 1'b0;
        #12;
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        resetn = 1'b1;
        #4;

        // Manual modes
        load(8'h81);
        check("load", q, 8'h81);
        mode = 2'b01; sr_ser = 1'b1; tick();
        check("shr", q, 8'hC0);
        mode = 2'b10; sl_ser = 1'b0; sr_ser = 1'b0; tick();
        check("shl", q, 8'h80);
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", q, 8'h80);
        end

        // Asynchronous reset between edges
        load(8'hA5);
        check("pre_rst", q, 8'hA5);
        #2 resetn = 1'b0;
        #1 check("async_rst", q, 8'h00);
        #1 resetn = 1'b1;
        load(8'h3C);
        check("post_rst_load", q, 8'h3C);

        // Burst left by 3; mode/d must be ignored while shifting
        load(8'h01);
        start = 1'b1; len = 4'd3; dir = 1'b1; sl_ser = 1'b0; tick();
        start = 1'b0; mode = 2'b11; d = 8'hFF;
        check("burst_start_q", q, 8'h01);
        check("burst_busy0", busy, 1);
        tick();
        check("burst_q1", q, 8'h02);
        check("burst_busy1", busy, 1);
        tick();
        check("burst_q2", q, 8'h04);
        check("burst_busy2", busy, 1);
        tick();
        check("burst_q3", q, 8'h08);
        check("burst_busy_end", busy, 0);
        check("burst_done", done, 1);
        tick();
        check("done_hold_q", q, 8'h08);
        check("done_clear", done, 0);
        mode = 2'b00;

        // len=0 goes straight to DONE
        start = 1'b1; len = 4'd0; tick();
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_q", q, 8'h08);
        tick();
        check("len0_done_off", done, 0);

        // Start reasserted mid-burst is dropped
        start = 1'b1; len = 4'd2; dir = 1'b0; sr_ser = 1'b0; tick();
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            len   = (i == 0) ? 4'd5 : 4'd0;
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        check("restart_dones", dones, 1);
        check("restart_q", q, 8'h02);

        // Abort with clr in the second SHIFT cycle
        load(8'hFF);
        start = 1'b1; len = 4'd5; dir = 1'b0; sr_ser = 1'b1; tick();
        start = 1'b0;
        tick();
        check("abort_pre_busy", busy, 1);
        clr = 1'b1; tick();
        clr = 1'b0;
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_dones", dones, 0);
        sr_ser = 1'b0;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        load(8'h81);
        rot = 1'b1; start = 1'b1; len = 4'd4; dir = 1'b0; tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rot = 1'b0;
        check("rot_q", q, 8'h18);
        check("rot_done", done, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
